clock_set_ctrl: RTL and testbench



---
 rtl/clock_set_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces the four front-panel buttons, runs the edit FSM
// and sequences freeze / step / load of the hour-minute-second counter chain.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       run_en,
  output logic       load,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic [1:0] field,
  output logic       editing
);

  // state   | meaning
  // RUN     | timekeeper counting, waiting for mode press
  // EDIT_H  | counting frozen, hour selected
  // EDIT_M  | counting frozen, minute selected
  // EDIT_S  | counting frozen, second selected
  // COMMIT  | one-cycle load of set_* into the timekeeper
  typedef enum logic [2:0] {RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [3:0]    sync1_q, sync2_q, db_q, db_d, press_q, press_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  state_t        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [4:0]    set_hour_q, set_hour_d;
  logic [5:0]    set_min_q, set_min_d, set_sec_q, set_sec_d;
  logic          run_en_q, run_en_d, load_q, load_d, editing_q, editing_d;
  logic [1:0]    field_q, field_d;
  logic          ev_mode, ev_next, ev_inc, ev_dec, ev_any;
  logic [5:0]    hour_step;

  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] maxv,
                                           input logic up);
    if (up) return (v >= maxv) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0 || v > maxv) ? maxv : v - 6'd1;
  endfunction

  always_comb begin
    db_d    = db_q;
    press_d = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]    = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Only the highest-priority press of a cycle becomes an event.
  always_comb begin
    ev_mode = press_q[3];
    ev_next = press_q[2] & ~press_q[3];
    ev_inc  = press_q[1] & ~|press_q[3:2];
    ev_dec  = press_q[0] & ~|press_q[3:1];
    ev_any  = |press_q;
  end

  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    hour_step  = step_wrap({1'b0, set_hour_q}, 6'd23, ev_inc);
    case (state_q)
      RUN: begin
        if (ev_mode) begin
          state_d    = EDIT_H;
          idle_d     = '0;
          set_hour_d = cur_hour;
          set_min_d  = cur_min;
          set_sec_d  = cur_sec;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (ev_any) begin
          idle_d = '0;
          if (ev_mode) begin
            state_d = COMMIT;
          end else if (ev_next) begin
            state_d = (state_q == EDIT_H) ? EDIT_M : (state_q == EDIT_M) ? EDIT_S : EDIT_H;
          end else if (ev_inc || ev_dec) begin
            case (state_q)
              EDIT_H:  set_hour_d = hour_step[4:0];
              EDIT_M:  set_min_d  = step_wrap(set_min_q, 6'd59, ev_inc);
              default: set_sec_d  = step_wrap(set_sec_q, 6'd59, ev_inc);
            endcase
          end
        end else if (TIMEOUT_CYCLES != 0 && idle_q == IDLE_LAST) begin
          state_d = RUN;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    run_en_d  = (state_d == RUN);
    load_d    = (state_d == COMMIT);
    editing_d = (state_d == EDIT_H) || (state_d == EDIT_M) || (state_d == EDIT_S);
    case (state_d)
      EDIT_H:  field_d = 2'd1;
      EDIT_M:  field_d = 2'd2;
      EDIT_S:  field_d = 2'd3;
      default: field_d = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      press_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q    <= RUN;
      idle_q     <= '0;
      set_hour_q <= '0;
      set_min_q  <= '0;
      set_sec_q  <= '0;
      run_en_q   <= 1'b1;
      load_q     <= 1'b0;
      editing_q  <= 1'b0;
      field_q    <= 2'd0;
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      press_q    <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      idle_q     <= idle_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
      run_en_q   <= run_en_d;
      load_q     <= load_d;
      editing_q  <= editing_d;
      field_q    <= field_d;
    end
  end

  assign run_en   = run_en_q;
  assign load     = load_q;
  assign set_hour = set_hour_q;
  assign set_min  = set_min_q;
  assign set_sec  = set_sec_q;
  assign field    = field_q;
  assign editing  = editing_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: button presses driven through the debouncer, outputs
// compared with a field-level model of the time-setting rules.
module tb_clock_set_ctrl;
  localparam int DB = 100;
  localparam int TO = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button = 4'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic       run_en, load, editing;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic [1:0] field;

  clock_set_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .button(button),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .run_en(run_en), .load(load), .set_hour(set_hour), .set_min(set_min),
    .set_sec(set_sec), .field(field), .editing(editing)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  // Reference model: edit flag, selected field and the three edited values.
  bit m_edit;
  int m_field, m_h, m_m, m_s;
  int exp_loads, exp_lh, exp_lm, exp_ls;

  int load_cnt = 0, cap_h, cap_m, cap_s;
  bit prev_load = 0;

  always @(negedge clock) begin
    if (reset) begin
      prev_load = 0;
    end else begin
      if (editing) begin
        checks++;
        if (run_en !== 1'b0) begin errors++; $display("FAIL run_en_in_edit: got %0b expected 0", run_en); end
      end
      if (load) begin
        load_cnt++; cap_h = set_hour; cap_m = set_min; cap_s = set_sec;
        checks++;
        if (run_en !== 1'b0 || prev_load) begin
          errors++; $display("FAIL load_cycle: run_en %0b prev_load %0b expected 0/0", run_en, prev_load);
        end
      end
      if (prev_load) begin
        checks++;
        if (run_en !== 1'b1) begin errors++; $display("FAIL run_en_after_load: got %0b expected 1", run_en); end
      end
      prev_load = load;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Wrap-around step on a 0..maxv field; out-of-range values go to 0 (up) or maxv (down).
  function automatic int adjust(input int v, input int maxv, input bit up);
    if (up) return (v > maxv) ? 0 : (v + 1) % (maxv + 1);
    else    return (v > maxv) ? maxv : (v + maxv) % (maxv + 1);
  endfunction

  task automatic model_apply(input logic [3:0] mask);
    if (mask[3]) begin
      if (!m_edit) begin
        m_edit = 1; m_field = 1; m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
      end else begin
        m_edit = 0; m_field = 0; exp_loads++; exp_lh = m_h; exp_lm = m_m; exp_ls = m_s;
      end
    end else if (m_edit && mask[2]) begin
      m_field = (m_field % 3) + 1;
    end else if (m_edit && mask[1:0] != 2'b00) begin
      if (m_field == 1) m_h = adjust(m_h, 23, mask[1]);
      else if (m_field == 2) m_m = adjust(m_m, 59, mask[1]);
      else m_s = adjust(m_s, 59, mask[1]);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    button = mask;
    tick(DB + 20);
    button = 4'b0;
    tick(DB + 20);
    model_apply(mask);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  task automatic test_reset;
    reset = 1; button = 0;
    tick(3);
    checks += 7;
    if (run_en !== 1'b1)   begin errors++; $display("FAIL reset_run_en: got %0b expected 1", run_en); end
    if (load !== 1'b0)     begin errors++; $display("FAIL reset_load: got %0b expected 0", load); end
    if (set_hour !== 5'd0) begin errors++; $display("FAIL reset_set_hour: got %0d expected 0", set_hour); end
    if (set_min !== 6'd0)  begin errors++; $display("FAIL reset_set_min: got %0d expected 0", set_min); end
    if (set_sec !== 6'd0)  begin errors++; $display("FAIL reset_set_sec: got %0d expected 0", set_sec); end
    if (field !== 2'd0)    begin errors++; $display("FAIL reset_field: got %0d expected 0", field); end
    if (editing !== 1'b0)  begin errors++; $display("FAIL reset_editing: got %0b expected 0", editing); end
    reset = 0;
    m_edit = 0; m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    tick(2);
  endtask

  task automatic test_glitch;
    set_cur(12, 34, 56);
    button = 4'b1000; tick(50); button = 4'b0; tick(2 * DB);
    checks += 2;
    if (editing !== 1'b0) begin errors++; $display("FAIL glitch_editing: got %0b expected 0", editing); end
    if (run_en !== 1'b1)  begin errors++; $display("FAIL glitch_run_en: got %0b expected 1", run_en); end
    button = 4'b1000;
    tick(DB + 2);
    checks++;
    if (editing !== 1'b0) begin errors++; $display("FAIL latency_early: got %0b expected 0 at edge %0d", editing, DB + 2); end
    tick(1);
    checks++;
    if (editing !== 1'b1) begin errors++; $display("FAIL latency_edge: got %0b expected 1 at edge %0d", editing, DB + 3); end
    tick(300 - (DB + 3));
    button = 4'b0;
    tick(DB + 20);
    model_apply(4'b1000);
    checks += 2;
    if (editing !== 1'b1) begin errors++; $display("FAIL long_pulse_single: editing %0b expected 1", editing); end
    if (field !== 2'd1)   begin errors++; $display("FAIL long_pulse_field: got %0d expected 1", field); end
    press(4'b1000);
    checks++;
    if (load_cnt !== exp_loads) begin errors++; $display("FAIL glitch_commit_loads: got %0d expected %0d", load_cnt, exp_loads); end
  endtask

  task automatic test_full_set;
    int loads0;
    loads0 = load_cnt;
    set_cur(12, 34, 56);
    press(4'b1000);
    checks += 2;
    if (field !== 2'd1)   begin errors++; $display("FAIL full_field_h: got %0d expected 1", field); end
    if (run_en !== 1'b0)  begin errors++; $display("FAIL full_run_en: got %0b expected 0", run_en); end
    press(4'b0010);
    press(4'b0100);
    checks++;
    if (field !== 2'd2)   begin errors++; $display("FAIL full_field_m: got %0d expected 2", field); end
    press(4'b0001);
    press(4'b0100);
    checks++;
    if (field !== 2'd3)   begin errors++; $display("FAIL full_field_s: got %0d expected 3", field); end
    press(4'b0010);
    press(4'b1000);
    checks += 3;
    if (load_cnt !== loads0 + 1) begin errors++; $display("FAIL full_load_count: got %0d expected %0d", load_cnt, loads0 + 1); end
    if (cap_h !== 13 || cap_m !== 33 || cap_s !== 57)
      begin errors++; $display("FAIL full_load_value: got %0d:%0d:%0d expected 13:33:57", cap_h, cap_m, cap_s); end
    if (run_en !== 1'b1 || editing !== 1'b0)
      begin errors++; $display("FAIL full_back_to_run: run_en %0b editing %0b expected 1/0", run_en, editing); end
  endtask

  task automatic test_wrap;
    set_cur(23, 0, 59);
    press(4'b1000); press(4'b0010); press(4'b0100); press(4'b0001);
    press(4'b0100); press(4'b0010); press(4'b1000);
    checks += 2;
    if (cap_h !== 0 || cap_m !== 59 || cap_s !== 0)
      begin errors++; $display("FAIL wrap_load_value: got %0d:%0d:%0d expected 0:59:0", cap_h, cap_m, cap_s); end
    if (load_cnt !== exp_loads) begin errors++; $display("FAIL wrap_load_count: got %0d expected %0d", load_cnt, exp_loads); end
  endtask

  task automatic test_timeout;
    int loads0, n;
    loads0 = load_cnt;
    set_cur(5, 6, 7);
    press(4'b1000);
    button = 4'b0010;
    n = 0;
    while (set_hour !== 5'd6 && n < 2 * DB) begin tick(1); n++; end
    checks++;
    if (set_hour !== 5'd6) begin errors++; $display("FAIL timeout_inc: got %0d expected 6", set_hour); end
    button = 4'b0;
    model_apply(4'b0010);
    n = 0;
    while (editing === 1'b1 && n < TO + 100) begin tick(1); n++; end
    m_edit = 0; m_field = 0;
    checks += 4;
    if (n !== TO) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); end
    if (run_en !== 1'b1) begin errors++; $display("FAIL timeout_run_en: got %0b expected 1", run_en); end
    if (field !== 2'd0)  begin errors++; $display("FAIL timeout_field: got %0d expected 0", field); end
    if (load_cnt !== loads0) begin errors++; $display("FAIL timeout_no_load: got %0d expected %0d", load_cnt, loads0); end
  endtask

  task automatic test_simultaneous;
    set_cur($urandom_range(0, 22), $urandom_range(0, 59), $urandom_range(0, 59));
    press(4'b1000);
    press(4'b0011);
    checks++;
    if (set_hour !== 5'(m_h)) begin errors++; $display("FAIL inc_dec_priority: got %0d expected %0d", set_hour, m_h); end
    press(4'b0100);
    press(4'b1010);
    checks += 3;
    if (load_cnt !== exp_loads) begin errors++; $display("FAIL mode_inc_loads: got %0d expected %0d", load_cnt, exp_loads); end
    if (cap_m !== int'(cur_min)) begin errors++; $display("FAIL mode_inc_minute: got %0d expected %0d", cap_m, cur_min); end
    if (cap_h !== exp_lh) begin errors++; $display("FAIL mode_inc_hour: got %0d expected %0d", cap_h, exp_lh); end
  endtask

  task automatic test_out_of_range;
    set_cur(30, 62, 63);
    press(4'b1000);
    checks += 3;
    if (set_hour !== 5'd30) begin errors++; $display("FAIL oor_hour_pass: got %0d expected 30", set_hour); end
    if (set_min !== 6'd62)  begin errors++; $display("FAIL oor_min_pass: got %0d expected 62", set_min); end
    if (set_sec !== 6'd63)  begin errors++; $display("FAIL oor_sec_pass: got %0d expected 63", set_sec); end
    press(4'b0001); press(4'b0100); press(4'b0010); press(4'b0100); press(4'b0001);
    press(4'b1000);
    checks++;
    if (cap_h !== 23 || cap_m !== 0 || cap_s !== 59)
      begin errors++; $display("FAIL oor_load_value: got %0d:%0d:%0d expected 23:0:59", cap_h, cap_m, cap_s); end
  endtask

  task automatic test_random;
    logic [3:0] ops [5];
    ops[0] = 4'b0100; ops[1] = 4'b0010; ops[2] = 4'b0001; ops[3] = 4'b0011; ops[4] = 4'b0110;
    for (int r = 0; r < 4; r++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      press(4'b1000);
      for (int k = 0; k < 7; k++) begin
        press(ops[$urandom_range(0, 4)]);
        checks += 2;
        if (field !== 2'(m_field)) begin errors++; $display("FAIL rand_field: got %0d expected %0d", field, m_field); end
        if (set_hour !== 5'(m_h) || set_min !== 6'(m_m) || set_sec !== 6'(m_s))
          begin errors++; $display("FAIL rand_values: got %0d:%0d:%0d expected %0d:%0d:%0d", set_hour, set_min, set_sec, m_h, m_m, m_s); end
      end
      press(4'b1000);
      checks += 2;
      if (load_cnt !== exp_loads) begin errors++; $display("FAIL rand_loads: got %0d expected %0d", load_cnt, exp_loads); end
      if (cap_h !== exp_lh || cap_m !== exp_lm || cap_s !== exp_ls)
        begin errors++; $display("FAIL rand_load_value: got %0d:%0d:%0d expected %0d:%0d:%0d", cap_h, cap_m, cap_s, exp_lh, exp_lm, exp_ls); end
    end
  endtask

  task automatic test_reset_mid_edit;
    int loads0;
    set_cur(9, 8, 7);
    press(4'b1000); press(4'b0100); press(4'b0100); press(4'b0010);
    checks++;
    if (field !== 2'd3) begin errors++; $display("FAIL mid_edit_field: got %0d expected 3", field); end
    loads0 = load_cnt;
    reset = 1;
    tick(1);
    checks += 4;
    if (editing !== 1'b0) begin errors++; $display("FAIL mid_reset_editing: got %0b expected 0", editing); end
    if (run_en !== 1'b1)  begin errors++; $display("FAIL mid_reset_run_en: got %0b expected 1", run_en); end
    if (load !== 1'b0)    begin errors++; $display("FAIL mid_reset_load: got %0b expected 0", load); end
    if (set_sec !== 6'd0) begin errors++; $display("FAIL mid_reset_set_sec: got %0d expected 0", set_sec); end
    reset = 0;
    m_edit = 0; m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    tick(DB);
    checks++;
    if (load_cnt !== loads0) begin errors++; $display("FAIL mid_reset_no_load: got %0d expected %0d", load_cnt, loads0); end
  endtask

  initial begin
    exp_loads = 0; exp_lh = 0; exp_lm = 0; exp_ls = 0;
    @(negedge clock);
    test_reset;
    test_glitch;
    test_full_set;
    test_wrap;
    test_timeout;
    test_simultaneous;
    test_out_of_range;
    test_random;
    test_reset_mid_edit;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
